pc_gen_ras: RTL and testbench
=============================

// Module: pc_gen_ras
// PURPOSE
//  Next-generation fetch PC generator: registered PC with ready/valid handshake to fetch,
//  NUM_REDIR prioritised redirect sources (flush/branch/exception) and a DEPTH-entry
//  return-address stack (RAS) for call/return prediction. Sits at the front of the fetch
//  stage and replaces the simple load/inc/stall PC.
// PARAMETERS
//  PC_WIDTH    32  PC width in bits
//  INC_AMOUNT  4   sequential increment, added modulo 2^PC_WIDTH
//  ALIGN_BITS  2   low bits forced to 0 on every loaded PC (redirect and RAS pop)
//  NUM_REDIR   3   number of redirect sources; index 0 has highest priority
//  RAS_DEPTH   4   RAS entries, >=2
// PORTS
//  clk           in   1                    clock
//  rst_n         in   1                    synchronous active-low reset
//  reset_vector  in   PC_WIDTH             PC loaded during reset
//  redirect_vld  in   NUM_REDIR            per-source redirect request
//  redirect_pc   in   NUM_REDIR*PC_WIDTH   packed targets; source i at [i*PC_WIDTH +: PC_WIDTH]
//  ras_flush     in   1                    empty the RAS (count := 0)
//  stall         in   1                    hold PC, deassert pc_valid
//  call          in   1                    qualifies current PC as a call (used on fire)
//  ret           in   1                    qualifies current PC as a return (used on fire)
//  pc_ready      in   1                    fetch accepts pc_out
//  pc_out        out  PC_WIDTH             current PC (registered)
//  pc_valid      out  1                    pc_out valid
//  ras_empty     out  1                    RAS count == 0
//  ras_full      out  1                    RAS count == RAS_DEPTH
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): pc_q<=reset_vector (not aligned), run_q<=0, RAS count<=0,
//    RAS pointer<=0. Outputs during/after reset: pc_valid=0, ras_empty=1, ras_full=0.
//  - run_q<=1 on first clk edge with rst_n=1; pc_valid = run_q & ~stall (combinational).
//  - fire = pc_valid & pc_ready. Handshake: pc_out stable while pc_valid & ~pc_ready.
//  - Next-PC priority, evaluated every cycle when run_q=1:
//      1. any redirect_vld: lowest set index i wins; pc_q<=align(redirect_pc[i]). Applies
//         regardless of stall/fire. RAS push/pop suppressed that cycle (instr squashed).
//      2. fire & ret & ~ras_empty: pc_q<=align(RAS top); pop.
//      3. fire: pc_q<=pc_q+INC_AMOUNT (wraps; 32'hFFFF_FFFC+4 -> 0).
//      4. otherwise hold.
//  - align(x) = {x[PC_WIDTH-1:ALIGN_BITS], ALIGN_BITS'b0}.
//  - RAS push: fire & call & no redirect; pushes pc_q+INC_AMOUNT.
//      full: circular overwrite of oldest entry, count stays RAS_DEPTH.
//  - ret with ras_empty: treated as sequential (rule 3); no pop, no underflow.
//  - call & ret on same fire, RAS non-empty: next PC = old top; top entry replaced with
//    pc_q+INC; count unchanged. Same with RAS empty: sequential next PC and a push.
//  - ras_flush: count<=0 next edge; has priority over push/pop in that cycle. Entry contents
//    are not cleared.
//  - Reset mid-operation: all state returns to reset values on that edge; inputs ignored.
//  - Latency: any next-PC decision is visible on pc_out one cycle later; no bypass.
// STRUCTURE
//  - pc_pkg: PC_WIDTH default, typedef logic [PC_WIDTH-1:0] pc_t, INC_AMOUNT default,
//    function align_pc().
//  - Sub-module ras_stack (circular buffer: ptr, count, push/pop/flush, top, empty, full).
//  - Registers are built from dff_rst_en_vector (pc_q) and dff_rst (run_q, ptr, count).
//  - Redirect select is a priority for-loop; no unique/priority casez on a one-hot vector.
// TESTING
//  1. Reset with reset_vector=32'h0000_1000, then pc_ready=1 for 3 cycles -> pc_valid=0 while
//     in reset; pc_out = 1000,1004,1008,100C.
//  2. pc_ready=0 for 2 cycles, then 1 -> pc_out held, pc_valid=1; advances by 4 on release.
//     stall=1 -> pc_valid=0, PC held.
//  3. redirect_vld=3'b110, pc[1]=32'h2003, pc[2]=32'h3000, with stall=1 -> next pc_out=2000.
//     Same cycle, call=1 and fire -> no push (ras_empty stays 1).
//  4. call at pc_out=100 then call at pc_out=200, then ret on fire -> next PC 204;
//     second ret -> 104; third ret -> sequential (108 + 4 path), ras_empty=1.
//  5. RAS_DEPTH=4: 5 calls at pc_out=10,20,30,40,50 -> ras_full=1.
//     4 rets -> 54,44,34,24 (14 overwritten).
//  6. call&ret on same fire with top=0x80 at pc_out=0x300 -> next PC 0x80, new top 0x304.
//     ras_flush -> ras_empty=1. Assert rst_n=0 mid-run -> pc_out=reset_vector, pc_valid=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared PC types, default geometry and the alignment helper for the fetch PC generator.
package pc_pkg;

    localparam int unsigned PC_WIDTH   = 32;
    localparam int unsigned INC_AMOUNT = 4;
    localparam int unsigned ALIGN_BITS = 2;
    localparam int unsigned NUM_REDIR  = 3;
    localparam int unsigned RAS_DEPTH  = 4;

    typedef logic [PC_WIDTH-1:0] pc_t;

    // Clear the low ALIGN_BITS of a loaded PC.
    function automatic pc_t align_pc(input pc_t pc);
        return {pc[PC_WIDTH-1:ALIGN_BITS], ALIGN_BITS'(0)};
    endfunction

endpackage

// File: rtl/dff_rst.sv
// Plain register with synchronous active-low reset to a constant.
module dff_rst #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) q <= RST_VAL;
        else        q <= d;
    end

endmodule

// File: rtl/dff_rst_en_vector.sv
// Enabled register with synchronous active-low reset to a run-time vector.
module dff_rst_en_vector #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n)  q <= rst_val;
        else if (en) q <= d;
    end

endmodule

// File: rtl/ras_stack.sv
// Circular return-address stack: pushes overwrite the oldest entry when full,
// push+pop together replace the top, flush empties without clearing contents.
module ras_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] w_ptr_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [PTR_W-1:0] w_ptr_dec;
    logic [PTR_W-1:0] w_widx;
    logic             w_we;

    // r_ptr is the next free slot; the top lives one below it.
    assign w_ptr_inc = (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
    assign w_ptr_dec = (r_ptr == '0) ? PTR_W'(DEPTH - 1) : r_ptr - PTR_W'(1);

    assign empty = (r_cnt == '0);
    assign full  = (r_cnt == CNT_W'(DEPTH));
    assign top   = r_mem[w_ptr_dec];

    always_comb begin
        w_ptr_d = r_ptr;
        w_cnt_d = r_cnt;
        w_we    = 1'b0;
        w_widx  = r_ptr;
        if (flush) begin
            w_cnt_d = '0;
        end else if (push && pop && !empty) begin
            w_we   = 1'b1;
            w_widx = w_ptr_dec;
        end else if (push) begin
            w_we    = 1'b1;
            w_ptr_d = w_ptr_inc;
            if (!full) w_cnt_d = r_cnt + CNT_W'(1);
        end else if (pop && !empty) begin
            w_ptr_d = w_ptr_dec;
            w_cnt_d = r_cnt - CNT_W'(1);
        end
    end

    dff_rst #(.W(PTR_W)) u_ptr (.clk(clk), .rst_n(rst_n), .d(w_ptr_d), .q(r_ptr));
    dff_rst #(.W(CNT_W)) u_cnt (.clk(clk), .rst_n(rst_n), .d(w_cnt_d), .q(r_cnt));

    // Entry storage is never reset; an empty count makes stale data unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && w_we) r_mem[w_widx] <= push_data;
    end

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch PC generator: registered PC with ready/valid handshake, prioritised
// redirects and a return-address stack for call/return prediction.
module pc_gen_ras
    import pc_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = pc_pkg::PC_WIDTH,
    parameter int unsigned INC_AMOUNT = pc_pkg::INC_AMOUNT,
    parameter int unsigned ALIGN_BITS = pc_pkg::ALIGN_BITS,
    parameter int unsigned NUM_REDIR  = pc_pkg::NUM_REDIR,
    parameter int unsigned RAS_DEPTH  = pc_pkg::RAS_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PC_WIDTH-1:0]           reset_vector,
    input  logic [NUM_REDIR-1:0]          redirect_vld,
    input  logic [NUM_REDIR*PC_WIDTH-1:0] redirect_pc,
    input  logic                          ras_flush,
    input  logic                          stall,
    input  logic                          call,
    input  logic                          ret,
    input  logic                          pc_ready,
    output logic [PC_WIDTH-1:0]           pc_out,
    output logic                          pc_valid,
    output logic                          ras_empty,
    output logic                          ras_full
);

    logic [PC_WIDTH-1:0] r_pc;
    logic                r_run;
    logic [PC_WIDTH-1:0] w_pc_d;
    logic                w_pc_en;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic                w_fire;
    logic                w_redir_any;
    logic [PC_WIDTH-1:0] w_redir_pc;
    logic [PC_WIDTH-1:0] w_redir_al;
    logic [PC_WIDTH-1:0] w_ras_top;
    logic [PC_WIDTH-1:0] w_ras_top_al;
    logic                w_push;
    logic                w_pop;

    assign pc_out   = r_pc;
    assign pc_valid = r_run & ~stall;
    assign w_fire   = pc_valid & pc_ready;
    assign w_pc_inc = r_pc + PC_WIDTH'(INC_AMOUNT);

    // Lowest-index asserted redirect source wins.
    always_comb begin
        w_redir_any = 1'b0;
        w_redir_pc  = '0;
        for (int unsigned i = 0; i < NUM_REDIR; i++) begin
            if (redirect_vld[i] && !w_redir_any) begin
                w_redir_any = 1'b1;
                w_redir_pc  = redirect_pc[i*PC_WIDTH +: PC_WIDTH];
            end
        end
    end

    assign w_redir_al   = {w_redir_pc[PC_WIDTH-1:ALIGN_BITS], ALIGN_BITS'(0)};
    assign w_ras_top_al = {w_ras_top[PC_WIDTH-1:ALIGN_BITS], ALIGN_BITS'(0)};

    // A redirect squashes the current instruction, so its call/ret is dropped.
    assign w_push = w_fire & call & ~w_redir_any;
    assign w_pop  = w_fire & ret & ~w_redir_any & ~ras_empty;

    always_comb begin
        w_pc_en = 1'b0;
        w_pc_d  = r_pc;
        if (r_run) begin
            if (w_redir_any) begin
                w_pc_en = 1'b1;
                w_pc_d  = w_redir_al;
            end else if (w_pop) begin
                w_pc_en = 1'b1;
                w_pc_d  = w_ras_top_al;
            end else if (w_fire) begin
                w_pc_en = 1'b1;
                w_pc_d  = w_pc_inc;
            end
        end
    end

    dff_rst_en_vector #(.W(PC_WIDTH)) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (w_pc_en),
        .rst_val (reset_vector),
        .d       (w_pc_d),
        .q       (r_pc)
    );

    dff_rst #(.W(1)) u_run (.clk(clk), .rst_n(rst_n), .d(1'b1), .q(r_run));

    ras_stack #(.DEPTH(RAS_DEPTH), .W(PC_WIDTH)) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (ras_flush),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top       (w_ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed bench for pc_gen_ras: handshake, redirects, RAS call/return and reset.
module tb_pc_gen_ras;

    logic        clk;
    logic        rst_n;
    logic [31:0] reset_vector;
    logic [2:0]  redirect_vld;
    logic [95:0] redirect_pc;
    logic        ras_flush;
    logic        stall;
    logic        call;
    logic        ret;
    logic        pc_ready;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        ras_empty;
    logic        ras_full;

    int n_vec;
    int n_err;

    pc_gen_ras dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reset_vector (reset_vector),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .ras_flush    (ras_flush),
        .stall        (stall),
        .call         (call),
        .ret          (ret),
        .pc_ready     (pc_ready),
        .pc_out       (pc_out),
        .pc_valid     (pc_valid),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_vld       = 3'b001;
        redirect_pc[31:0]  = pc;
        tick();
        redirect_vld       = 3'b000;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h1004; exp_pc[1] = 32'h1008; exp_pc[2] = 32'h100C;
        tick(); tick();
        n_vec++; if (pc_out !== 32'h1000) begin n_err++; $display("FAIL rst_pc got %h want %h", pc_out, 32'h1000); end
        n_vec++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", pc_valid); end
        n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b want 1", ras_empty); end
        n_vec++; if (ras_full !== 1'b0) begin n_err++; $display("FAIL rst_full got %b want 0", ras_full); end
        rst_n = 1'b1;
        tick();
        n_vec++; if (pc_valid !== 1'b1) begin n_err++; $display("FAIL run_valid got %b want 1", pc_valid); end
        n_vec++; if (pc_out !== 32'h1000) begin n_err++; $display("FAIL run_pc0 got %h want %h", pc_out, 32'h1000); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (pc_out !== exp_pc[i]) begin n_err++; $display("FAIL seq_pc%0d got %h want %h", i, pc_out, exp_pc[i]); end
        end
    endtask

    task automatic test_handshake();
        pc_ready = 1'b0;
        #1;
        n_vec++; if (pc_valid !== 1'b1) begin n_err++; $display("FAIL hs_valid got %b want 1", pc_valid); end
        tick();
        n_vec++; if (pc_out !== 32'h100C) begin n_err++; $display("FAIL hs_hold1 got %h want %h", pc_out, 32'h100C); end
        tick();
        n_vec++; if (pc_out !== 32'h100C) begin n_err++; $display("FAIL hs_hold2 got %h want %h", pc_out, 32'h100C); end
        pc_ready = 1'b1;
        tick();
        n_vec++; if (pc_out !== 32'h1010) begin n_err++; $display("FAIL hs_release got %h want %h", pc_out, 32'h1010); end
        stall = 1'b1;
        #1;
        n_vec++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL stall_valid got %b want 0", pc_valid); end
        tick();
        n_vec++; if (pc_out !== 32'h1010) begin n_err++; $display("FAIL stall_hold got %h want %h", pc_out, 32'h1010); end
        stall = 1'b0;
    endtask

    task automatic test_redirect();
        redirect_vld = 3'b110;
        redirect_pc  = {32'h0000_3000, 32'h0000_2003, 32'h0000_0000};
        stall = 1'b1;
        call  = 1'b1;
        tick();
        n_vec++; if (pc_out !== 32'h2000) begin n_err++; $display("FAIL redir_prio got %h want %h", pc_out, 32'h2000); end
        n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL redir_stall_nopush got %b want 1", ras_empty); end
        stall = 1'b0;
        redirect_vld = 3'b100;
        tick();
        n_vec++; if (pc_out !== 32'h3000) begin n_err++; $display("FAIL redir_src2 got %h want %h", pc_out, 32'h3000); end
        n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL redir_fire_nopush got %b want 1", ras_empty); end
        redirect_vld = 3'b000;
        call = 1'b0;
    endtask

    task automatic test_call_ret();
        do_redirect(32'h100);
        call = 1'b1; tick(); call = 1'b0;
        do_redirect(32'h200);
        call = 1'b1; tick(); call = 1'b0;
        ret = 1'b1;
        tick();
        n_vec++; if (pc_out !== 32'h204) begin n_err++; $display("FAIL ret1 got %h want %h", pc_out, 32'h204); end
        tick();
        n_vec++; if (pc_out !== 32'h104) begin n_err++; $display("FAIL ret2 got %h want %h", pc_out, 32'h104); end
        n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL ret2_empty got %b want 1", ras_empty); end
        tick();
        n_vec++; if (pc_out !== 32'h108) begin n_err++; $display("FAIL ret_underflow got %h want %h", pc_out, 32'h108); end
        n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL ret3_empty got %b want 1", ras_empty); end
        ret = 1'b0;
    endtask

    task automatic test_ras_full();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h54; exp_pc[1] = 32'h44; exp_pc[2] = 32'h34; exp_pc[3] = 32'h24;
        for (int k = 1; k <= 5; k++) begin
            do_redirect(32'(k * 16));
            call = 1'b1; tick(); call = 1'b0;
        end
        n_vec++; if (ras_full !== 1'b1) begin n_err++; $display("FAIL full_flag got %b want 1", ras_full); end
        n_vec++; if (ras_empty !== 1'b0) begin n_err++; $display("FAIL full_empty got %b want 0", ras_empty); end
        ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (pc_out !== exp_pc[i]) begin n_err++; $display("FAIL full_ret%0d got %h want %h", i, pc_out, exp_pc[i]); end
        end
        ret = 1'b0;
        n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL full_drained got %b want 1", ras_empty); end
        n_vec++; if (ras_full !== 1'b0) begin n_err++; $display("FAIL full_cleared got %b want 0", ras_full); end
    endtask

    task automatic test_call_ret_same();
        do_redirect(32'h7C);
        call = 1'b1; tick(); call = 1'b0;
        do_redirect(32'h300);
        call = 1'b1; ret = 1'b1;
        tick();
        n_vec++; if (pc_out !== 32'h80) begin n_err++; $display("FAIL cr_pc got %h want %h", pc_out, 32'h80); end
        n_vec++; if (ras_empty !== 1'b0) begin n_err++; $display("FAIL cr_count got %b want 0", ras_empty); end
        call = 1'b0;
        tick();
        n_vec++; if (pc_out !== 32'h304) begin n_err++; $display("FAIL cr_newtop got %h want %h", pc_out, 32'h304); end
        n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL cr_empty got %b want 1", ras_empty); end
        ret = 1'b0;
    endtask

    task automatic test_flush();
        call = 1'b1; tick(); call = 1'b0;
        n_vec++; if (ras_empty !== 1'b0) begin n_err++; $display("FAIL fl_pushed got %b want 0", ras_empty); end
        ras_flush = 1'b1;
        tick();
        n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL fl_empty got %b want 1", ras_empty); end
        call = 1'b1;
        tick();
        n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL fl_over_push got %b want 1", ras_empty); end
        ras_flush = 1'b0;
        call = 1'b0;
    endtask

    task automatic test_wrap();
        do_redirect(32'hFFFF_FFFC);
        n_vec++; if (pc_out !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pre got %h want %h", pc_out, 32'hFFFF_FFFC); end
        tick();
        n_vec++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL wrap_zero got %h want %h", pc_out, 32'h0); end
    endtask

    task automatic test_reset_mid();
        call = 1'b1; tick(); call = 1'b0;
        n_vec++; if (ras_empty !== 1'b0) begin n_err++; $display("FAIL mid_pushed got %b want 0", ras_empty); end
        rst_n = 1'b0;
        reset_vector = 32'h0000_5000;
        redirect_vld = 3'b001;
        redirect_pc[31:0] = 32'h0000_9000;
        tick();
        n_vec++; if (pc_out !== 32'h5000) begin n_err++; $display("FAIL mid_pc got %h want %h", pc_out, 32'h5000); end
        n_vec++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b want 0", pc_valid); end
        n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL mid_empty got %b want 1", ras_empty); end
        redirect_vld = 3'b000;
        rst_n = 1'b1;
        tick();
        n_vec++; if (pc_valid !== 1'b1 || pc_out !== 32'h5000) begin n_err++; $display("FAIL mid_restart got %b/%h want 1/%h", pc_valid, pc_out, 32'h5000); end
        tick();
        n_vec++; if (pc_out !== 32'h5004) begin n_err++; $display("FAIL mid_seq got %h want %h", pc_out, 32'h5004); end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        reset_vector = 32'h0000_1000;
        redirect_vld = 3'b000;
        redirect_pc  = '0;
        ras_flush    = 1'b0;
        stall        = 1'b0;
        call         = 1'b0;
        ret          = 1'b0;
        pc_ready     = 1'b1;
        test_reset();
        test_handshake();
        test_redirect();
        test_call_ret();
        test_ras_full();
        test_call_ret_same();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
